// File: rtl/rr_receiver_queue_if.sv
// Handshake/bus bundle for rr_receiver_queue.
//   in_sig       : NCH packed input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid     : per-channel word present
//   in_ready     : per-channel FIFO not full
//   selected_sig : registered output word
//   sig_alert    : selected_sig holds a valid word
//   s            : source channel of selected_sig
//   out_ready    : consumer takes the word this cycle
//   overflow     : sticky per-channel drop flag
// slave = the queue itself, master = the node driving/consuming it.
interface rr_receiver_queue_if #(
   parameter int WIDTH = 32,
   parameter int NCH   = 3
);
   localparam int SW = (NCH > 2) ? $clog2(NCH) : 1;

   logic [NCH*WIDTH-1:0] in_sig;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic [WIDTH-1:0]     selected_sig;
   logic                 sig_alert;
   logic [SW-1:0]        s;
   logic                 out_ready;
   logic [NCH-1:0]       overflow;

   modport master (
      output in_sig, in_valid, out_ready,
      input  in_ready, selected_sig, sig_alert, s, overflow
   );

   modport slave (
      input  in_sig, in_valid, out_ready,
      output in_ready, selected_sig, sig_alert, s, overflow
   );
endinterface

// File: rtl/rr_receiver_queue.sv
// Receive stage: NCH per-channel FIFOs of DEPTH words, round-robin
// arbitration onto one registered valid/ready output.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : rr_receiver_queue_if.slave (inputs, readiness, output word,
//             source index, overflow flags)
//
// Output register state:
//   state    | meaning
//   ST_IDLE  | selected_sig not valid (sig_alert = 0)
//   ST_VALID | selected_sig valid, waiting for out_ready
module rr_receiver_queue #(
   parameter int WIDTH = 32,
   parameter int NCH   = 3,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   rr_receiver_queue_if.slave  bus
);
   localparam int SW = (NCH > 2) ? $clog2(NCH) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   logic [WIDTH-1:0] r_mem    [NCH][DEPTH];
   logic [PW-1:0]    r_wr_ptr [NCH];
   logic [PW-1:0]    r_rd_ptr [NCH];

   logic [NCH-1:0]   w_full;
   logic [NCH-1:0]   w_empty;
   logic [NCH-1:0]   w_push;
   logic [NCH-1:0]   w_pop;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_data;
   logic [SW-1:0]    r_src;
   logic [SW-1:0]    r_last;
   logic [NCH-1:0]   r_overflow;

   logic [SW-1:0]    w_winner;
   logic             w_found;
   logic             w_load;
   logic [WIDTH-1:0] w_head;

   // Extra MSB on the pointers distinguishes full from empty when the
   // index bits match.
   for (genvar g = 0; g < NCH; g++) begin : g_flags
      assign w_empty[g] = (r_wr_ptr[g] == r_rd_ptr[g]);
      assign w_full[g]  = (r_wr_ptr[g][PW-1] != r_rd_ptr[g][PW-1]) &&
                          (r_wr_ptr[g][AW-1:0] == r_rd_ptr[g][AW-1:0]);
      assign w_pop[g]   = w_load && (w_winner == SW'(g));
   end

   // Readiness comes from registered state only, so a full FIFO refuses
   // a word even on the cycle it is being popped.
   assign w_push = bus.in_valid & ~w_full;

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      int w_idx;
      w_idx    = 0;
      w_winner = '0;
      w_found  = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         w_idx = (int'(r_last) + k) % NCH;
         if (!w_found && !w_empty[w_idx]) begin
            w_found  = 1'b1;
            w_winner = SW'(w_idx);
         end
      end
   end

   assign w_head = r_mem[w_winner][r_rd_ptr[w_winner][AW-1:0]];

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_load      = 1'b1;
               w_state_nxt = ST_VALID;
            end
         end
         ST_VALID: begin
            if (bus.out_ready) begin
               if (w_found) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_data     <= '0;
         r_src      <= '0;
         r_last     <= SW'(NCH - 1);
         r_overflow <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_overflow <= r_overflow | (bus.in_valid & w_full);
         if (w_load) begin
            r_data <= w_head;
            r_src  <= w_winner;
            r_last <= w_winner;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_push[i]) begin
               r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
            end
            if (w_pop[i]) begin
               r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
            end
         end
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (w_push[i]) begin
            r_mem[i][r_wr_ptr[i][AW-1:0]] <= bus.in_sig[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.in_ready     = ~w_full;
   assign bus.selected_sig = r_data;
   assign bus.sig_alert    = (r_state == ST_VALID);
   assign bus.s            = r_src;
   assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_rr_receiver_queue.sv
module tb_rr_receiver_queue;
   localparam int WIDTH = 32;
   localparam int NCH   = 3;
   localparam int DEPTH = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   rr_receiver_queue_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

   rr_receiver_queue #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: per-channel queues plus one output slot.
   logic [WIDTH-1:0] mq [NCH][$];
   bit               mv    = 1'b0;
   logic [WIDTH-1:0] md    = '0;
   int               ms    = 0;
   int               mlast = NCH - 1;
   logic [NCH-1:0]   movf  = '0;

   always @(posedge clk or negedge reset_n) begin : model
      bit             any;
      int             w;
      bit [NCH-1:0]   rdy;
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) mq[i].delete();
         mv    = 1'b0;
         md    = '0;
         ms    = 0;
         mlast = NCH - 1;
         movf  = '0;
      end else begin
         any = 1'b0;
         w   = 0;
         for (int i = 0; i < NCH; i++) rdy[i] = (mq[i].size() < DEPTH);
         for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (mlast + k) % NCH;
            if (!any && mq[c].size() > 0) begin
               any = 1'b1;
               w   = c;
            end
         end
         if ((!mv || bus.out_ready) && any) begin
            md    = mq[w].pop_front();
            ms    = w;
            mv    = 1'b1;
            mlast = w;
         end else if (mv && bus.out_ready) begin
            mv = 1'b0;
         end
         for (int i = 0; i < NCH; i++) begin
            if (bus.in_valid[i]) begin
               if (rdy[i]) mq[i].push_back(bus.in_sig[i*WIDTH +: WIDTH]);
               else        movf[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [NCH-1:0] mrdy;
      for (int i = 0; i < NCH; i++) mrdy[i] = (mq[i].size() < DEPTH);
      chk("m_alert", bus.sig_alert, mv);
      chk("m_data", bus.selected_sig, md);
      chk("m_src", bus.s, ms);
      chk("m_ready", bus.in_ready, mrdy);
      chk("m_ovf", bus.overflow, movf);
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic setin(input logic [NCH-1:0] v, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] d2);
      bus.in_valid = v;
      bus.in_sig   = {d2, d1, d0};
   endtask

   initial begin
      int thr;
      bus.in_valid  = '0;
      bus.in_sig    = '0;
      bus.out_ready = 1'b0;
      reset_n       = 1'b0;
      #1;
      chk("rst_alert", bus.sig_alert, 1'b0);
      chk("rst_ready", bus.in_ready, 3'b111);
      cyc(2);
      reset_n = 1'b1;

      // single word on ch2
      setin(3'b100, 0, 0, 42);
      bus.out_ready = 1'b1;
      cyc();
      setin(3'b000, 0, 0, 0);
      cyc();
      chk("sw_alert", bus.sig_alert, 1'b1);
      chk("sw_data", bus.selected_sig, 42);
      chk("sw_src", bus.s, 2);
      cyc();
      chk("sw_drain", bus.sig_alert, 1'b0);

      // round robin, twice
      for (int rep = 0; rep < 2; rep++) begin
         setin(3'b111, 89, 73, 42);
         cyc();
         setin(3'b000, 0, 0, 0);
         cyc();
         chk("rr_d0", bus.selected_sig, 89);
         chk("rr_s0", bus.s, 0);
         cyc();
         chk("rr_d1", bus.selected_sig, 73);
         chk("rr_s1", bus.s, 1);
         cyc();
         chk("rr_d2", bus.selected_sig, 42);
         chk("rr_s2", bus.s, 2);
         cyc();
         chk("rr_drain", bus.sig_alert, 1'b0);
      end

      // back-pressure and overflow on ch0
      bus.out_ready = 1'b0;
      for (int v = 1; v <= 6; v++) begin
         setin(3'b001, v, 0, 0);
         cyc();
         if (v == 5) chk("bp_full_ready", bus.in_ready, 3'b110);
      end
      chk("bp_ovf", bus.overflow, 3'b001);
      chk("bp_hold", bus.selected_sig, 1);
      setin(3'b000, 0, 0, 0);
      bus.out_ready = 1'b1;
      for (int v = 2; v <= 5; v++) begin
         cyc();
         chk("bp_out", bus.selected_sig, v);
      end
      cyc();
      chk("bp_drain", bus.sig_alert, 1'b0);
      chk("bp_ovf_sticky", bus.overflow, 3'b001);

      // full FIFO on ch1 with a simultaneous pop
      bus.out_ready = 1'b0;
      for (int v = 10; v <= 14; v++) begin
         setin(3'b010, 0, v, 0);
         cyc();
      end
      chk("fp_full", bus.in_ready, 3'b101);
      setin(3'b010, 0, 500, 0);
      bus.out_ready = 1'b1;
      cyc();
      setin(3'b000, 0, 0, 0);
      chk("fp_data", bus.selected_sig, 11);
      chk("fp_ovf", bus.overflow, 3'b011);
      chk("fp_ready", bus.in_ready, 3'b111);
      for (int v = 12; v <= 14; v++) begin
         cyc();
         chk("fp_out", bus.selected_sig, v);
      end
      cyc();
      chk("fp_drain", bus.sig_alert, 1'b0);

      // reset mid-operation
      bus.out_ready = 1'b0;
      setin(3'b111, 7, 8, 9);
      cyc(2);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mr_alert", bus.sig_alert, 1'b0);
      chk("mr_data", bus.selected_sig, 0);
      chk("mr_src", bus.s, 0);
      chk("mr_ovf", bus.overflow, 3'b000);
      chk("mr_ready", bus.in_ready, 3'b111);
      cyc();
      reset_n = 1'b1;
      setin(3'b011, 4, 800, 0);
      bus.out_ready = 1'b1;
      cyc();
      setin(3'b000, 0, 0, 0);
      cyc();
      chk("mr_d0", bus.selected_sig, 4);
      chk("mr_s0", bus.s, 0);
      cyc();
      chk("mr_d1", bus.selected_sig, 800);
      chk("mr_s1", bus.s, 1);
      cyc();
      chk("mr_drain", bus.sig_alert, 1'b0);

      // randomized traffic with varying consumer pressure
      for (int i = 0; i < 3000; i++) begin
         case ((i / 500) % 3)
            0:       thr = 2;
            1:       thr = 9;
            default: thr = 5;
         endcase
         if (i == 1500) reset_n = 1'b0;
         if (i == 1502) reset_n = 1'b1;
         setin(NCH'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
         bus.out_ready = ($urandom_range(0, 9) < thr);
         cyc();
      end

      setin(3'b000, 0, 0, 0);
      bus.out_ready = 1'b1;
      cyc(20);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
